management_bus_bridge: RTL and testbench

MANAGEMENT_BUS_BRIDGE -- requirements
Module: management_bus_bridge

---
 rtl/management_bus_bridge_pkg.sv | 17 +
 rtl/management_bus_bridge_timeout.sv | 27 ++
 rtl/management_bus_bridge.sv | 124 ++++++++++++
 tb/tb_management_bus_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/management_bus_bridge_pkg.sv
// Shared definitions for the management-to-Wishbone bridge: FSM encoding,
// default error read data and the word-to-byte address mapping.
package management_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS      = 2'd1,
    ST_COMPLETE = 2'd2
  } bridge_state_t;

  localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEADBEEF;

  function automatic logic [23:0] word_to_byte_addr(input logic [19:0] word_addr);
    return {2'b00, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/management_bus_bridge_timeout.sv
// Bus-cycle watchdog: counts while enabled, flags the cycle on which the
// count would reach LIMIT so the bridge aborts after exactly LIMIT bus cycles.
module bridge_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_enable && (r_count == 8'(LIMIT - 1));

endmodule

// File: rtl/management_bus_bridge.sv
// Bridges single JTAG management requests onto a Wishbone master port with
// timeout, error capture and sticky error/overrun status.
module management_bus_bridge
  import management_bus_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        management_enable,
  input  logic        management_writeEnable,
  input  logic [3:0]  management_byteSelect,
  input  logic [19:0] management_address,
  input  logic [31:0] management_writeData,
  output logic [31:0] management_readData,
  output logic        management_busy,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [23:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        status_clear,
  output logic        status_error,
  output logic        status_overrun
);

  bridge_state_t r_state;
  logic          r_en_d;
  logic          r_armed;
  logic          w_en_rise;
  logic          w_in_bus;
  logic          w_expired;

  // r_armed keeps the first clock after reset release from seeing an edge
  assign w_en_rise = management_enable & ~r_en_d & r_armed;
  assign w_in_bus  = (r_state == ST_BUS);
  assign management_busy = (r_state != ST_IDLE);

  bridge_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst),
    .i_clear   (~w_in_bus),
    .i_enable  (w_in_bus),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= ST_IDLE;
      r_en_d              <= 1'b0;
      r_armed             <= 1'b0;
      wb_cyc_o            <= 1'b0;
      wb_stb_o            <= 1'b0;
      wb_we_o             <= 1'b0;
      wb_sel_o            <= '0;
      wb_adr_o            <= '0;
      wb_dat_o            <= '0;
      management_readData <= '0;
      status_error        <= 1'b0;
      status_overrun      <= 1'b0;
    end else begin
      r_en_d  <= management_enable;
      r_armed <= 1'b1;
      // Clear first so any set event below in the same cycle takes priority
      if (status_clear) begin
        status_error   <= 1'b0;
        status_overrun <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_en_rise) begin
            wb_we_o  <= management_writeEnable;
            wb_sel_o <= management_byteSelect;
            wb_adr_o <= word_to_byte_addr(management_address);
            wb_dat_o <= management_writeEnable ? management_writeData : 32'h0;
            if (management_byteSelect != 4'h0) begin
              r_state  <= ST_BUS;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
            end else begin
              status_error <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (w_en_rise) begin
            status_overrun <= 1'b1;
          end
          if (wb_err_i || w_expired) begin
            r_state      <= ST_COMPLETE;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            status_error <= 1'b1;
            if (!wb_we_o) begin
              management_readData <= ERROR_DATA;
            end
          end else if (wb_ack_i) begin
            r_state  <= ST_COMPLETE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) begin
              management_readData <= wb_dat_i;
            end
          end
        end
        ST_COMPLETE: begin
          if (w_en_rise) begin
            status_overrun <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_management_bus_bridge.sv
// Scoreboard bench for management_bus_bridge: expected bus cycles are queued
// at request time and checked when the bridge opens the Wishbone cycle.
module tb_management_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        management_enable = 1'b0;
  logic        management_writeEnable = 1'b0;
  logic [3:0]  management_byteSelect = 4'h0;
  logic [19:0] management_address = 20'h0;
  logic [31:0] management_writeData = 32'h0;
  logic [31:0] management_readData;
  logic        management_busy;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [23:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        status_clear = 1'b0;
  logic        status_error, status_overrun;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [23:0] adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       mon_e;
  int          n_vec = 0;
  int          n_miscmp = 0;
  int          n_cycles = 0;
  int          base;
  int          n;
  int          s_mode = 0;   // 0 silent, 1 ack, 2 err, 3 ack+err
  int          s_delay = 0;
  int          s_cnt = 0;
  logic [31:0] s_data = 32'h0;
  logic        prev_cyc = 1'b0;

  always #5 clk = ~clk;

  management_bus_bridge #(
    .TIMEOUT_CYCLES (255),
    .ERROR_DATA     (32'hDEADBEEF)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .management_enable      (management_enable),
    .management_writeEnable (management_writeEnable),
    .management_byteSelect  (management_byteSelect),
    .management_address     (management_address),
    .management_writeData   (management_writeData),
    .management_readData    (management_readData),
    .management_busy        (management_busy),
    .wb_cyc_o               (wb_cyc_o),
    .wb_stb_o               (wb_stb_o),
    .wb_we_o                (wb_we_o),
    .wb_sel_o               (wb_sel_o),
    .wb_adr_o               (wb_adr_o),
    .wb_dat_o               (wb_dat_o),
    .wb_dat_i               (wb_dat_i),
    .wb_ack_i               (wb_ack_i),
    .wb_err_i               (wb_err_i),
    .status_clear           (status_clear),
    .status_error           (status_error),
    .status_overrun         (status_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Slave model and bus-cycle monitor, both on the falling edge
  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_cyc_o) begin
      if (!prev_cyc) begin
        n_cycles++;
        chk("cycle_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("mon_adr", 32'(wb_adr_o), 32'(mon_e.adr));
          chk("mon_sel", 32'(wb_sel_o), 32'(mon_e.sel));
          chk("mon_we",  32'(wb_we_o),  32'(mon_e.we));
          chk("mon_dat", wb_dat_o, mon_e.dat);
          chk("mon_stb", 32'(wb_stb_o), 32'd1);
        end
      end
      if (s_mode != 0 && s_cnt == s_delay) begin
        if (s_mode == 1 || s_mode == 3) begin
          wb_ack_i = 1'b1;
          wb_dat_i = s_data;
        end
        if (s_mode >= 2) wb_err_i = 1'b1;
      end
      s_cnt++;
    end else begin
      s_cnt = 0;
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [3:0] sel, input logic [19:0] addr,
                     input logic [31:0] data);
    xfer_t e;
    management_enable      = 1'b1;
    management_writeEnable = we;
    management_byteSelect  = sel;
    management_address     = addr;
    management_writeData   = data;
    if (sel != 4'h0) begin
      e.we  = we;
      e.sel = sel;
      e.adr = {2'b00, addr, 2'b00};
      e.dat = we ? data : 32'h0;
      exp_q.push_back(e);
    end
    tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (management_busy && k < 400) begin
      k++;
      tick();
    end
    chk("idle_reached", 32'(management_busy), 32'd0);
  endtask

  task automatic clear_flags();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_cyc",     32'(wb_cyc_o), 32'd0);
    chk("rst_adr",     32'(wb_adr_o), 32'd0);
    chk("rst_rdata",   management_readData, 32'd0);
    chk("rst_busy",    32'(management_busy), 32'd0);
    chk("rst_err",     32'(status_error), 32'd0);
    chk("rst_ovr",     32'(status_overrun), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Read, ack 3 cycles after strobe, enable held for two cycles
    s_mode = 1; s_delay = 3; s_data = 32'h12345678; base = n_cycles;
    req(1'b0, 4'hF, 20'h00010, 32'hAAAA5555);
    chk("rd_cyc_n1", 32'(wb_cyc_o), 32'd1);
    chk("rd_adr",    32'(wb_adr_o), 32'h000040);
    tick();
    management_enable = 1'b0;
    chk("rd_dat_o_zero", wb_dat_o, 32'h0);
    tick(); tick();
    chk("rd_cyc_at_ack", 32'(wb_cyc_o), 32'd1);
    chk("rd_data_before", management_readData, 32'h0);
    tick();
    chk("rd_data",       management_readData, 32'h12345678);
    chk("rd_cyc_low",    32'(wb_cyc_o), 32'd0);
    chk("rd_busy_m1",    32'(management_busy), 32'd1);
    tick();
    chk("rd_busy_m2",    32'(management_busy), 32'd0);
    chk("rd_one_cycle",  32'(n_cycles - base), 32'd1);

    // Write, immediate ack
    s_mode = 1; s_delay = 0; s_data = 32'h55555555;
    req(1'b1, 4'h3, 20'h00004, 32'hCAFE0001);
    management_enable = 1'b0;
    chk("wr_we",  32'(wb_we_o), 32'd1);
    chk("wr_sel", 32'(wb_sel_o), 32'h3);
    chk("wr_dat", wb_dat_o, 32'hCAFE0001);
    tick();
    chk("wr_cyc_low", 32'(wb_cyc_o), 32'd0);
    wait_idle();
    chk("wr_rdata_kept", management_readData, 32'h12345678);
    chk("wr_no_err", 32'(status_error), 32'd0);

    // Silent slave: timeout
    s_mode = 0;
    req(1'b0, 4'hF, 20'h00123, 32'h0);
    management_enable = 1'b0;
    n = 0;
    while (wb_cyc_o === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    chk("to_len",   32'(n), 32'd255);
    chk("to_rdata", management_readData, 32'hDEADBEEF);
    chk("to_err",   32'(status_error), 32'd1);
    wait_idle();
    clear_flags();
    chk("clr_err", 32'(status_error), 32'd0);

    // Ack and err together: err wins
    s_mode = 3; s_delay = 1; s_data = 32'h11112222;
    req(1'b0, 4'hF, 20'h00200, 32'h0);
    management_enable = 1'b0;
    wait_idle();
    chk("err_rdata", management_readData, 32'hDEADBEEF);
    chk("err_flag",  32'(status_error), 32'd1);
    clear_flags();

    // Second edge during BUS, coinciding with status_clear
    s_mode = 1; s_delay = 4; s_data = 32'h0BADF00D; base = n_cycles;
    req(1'b0, 4'hF, 20'h00300, 32'h0);
    management_enable = 1'b0;
    tick();
    management_enable = 1'b1;
    status_clear = 1'b1;
    tick();
    management_enable = 1'b0;
    status_clear = 1'b0;
    chk("ovr_set_wins", 32'(status_overrun), 32'd1);
    chk("ovr_busy",     32'(management_busy), 32'd1);
    wait_idle();
    repeat (3) tick();
    chk("ovr_rdata",     management_readData, 32'h0BADF00D);
    chk("ovr_one_cycle", 32'(n_cycles - base), 32'd1);
    clear_flags();
    chk("ovr_cleared",   32'(status_overrun), 32'd0);

    // byteSelect == 0: no bus cycle, error flagged
    base = n_cycles;
    req(1'b0, 4'h0, 20'h00400, 32'h0);
    management_enable = 1'b0;
    repeat (3) tick();
    chk("sel0_no_cycle", 32'(n_cycles - base), 32'd0);
    chk("sel0_err",      32'(status_error), 32'd1);
    chk("sel0_busy",     32'(management_busy), 32'd0);
    clear_flags();

    // Reset asserted mid-transfer
    s_mode = 0;
    req(1'b0, 4'hF, 20'h00500, 32'h0);
    management_enable = 1'b0;
    tick(); tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cyc",   32'(wb_cyc_o), 32'd0);
    chk("arst_stb",   32'(wb_stb_o), 32'd0);
    chk("arst_adr",   32'(wb_adr_o), 32'd0);
    chk("arst_sel",   32'(wb_sel_o), 32'd0);
    chk("arst_busy",  32'(management_busy), 32'd0);
    chk("arst_rdata", management_readData, 32'd0);
    tick();
    rst = 1'b1;
    base = n_cycles;
    repeat (10) tick();
    chk("arst_no_retry", 32'(n_cycles - base), 32'd0);
    chk("arst_idle",     32'(management_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
